i2c_master_sequencer: RTL

- Master-side control FSM for `i2c_data_path_block`: generates SCL, the phase counter `counter_detect_edge_o`, the one-hot state strobes and the repeated-start timer that the datapath consumes.
- Also tracks the remaining-byte count, slave ACK/NACK and the host handshakes (`data_req_o`, `rx_valid_o`).
- Sits between the register/host interface and the datapath; the datapath output `counter_data_ack` feeds back into it.

---
 rtl/i2c_master_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/i2c_master_sequencer.sv
// Master-side I2C control FSM: SCL generation, phase counter, one-hot state
// strobes, repeated-start timer, byte accounting and host handshakes.
module i2c_master_sequencer #(
    parameter int REP_TIME = 4
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       enable_i,
    input  logic       repeat_start_i,
    input  logic [7:0] addr_rw_i,
    input  logic [7:0] num_bytes_i,
    input  logic [7:0] prescaler_i,
    input  logic       sda_i,
    input  logic [7:0] counter_data_ack_i,
    output logic       start_cnt_o,
    output logic       write_addr_cnt_o,
    output logic       write_data_cnt_o,
    output logic       read_data_cnt_o,
    output logic       write_ack_cnt_o,
    output logic       read_ack_cnt_o,
    output logic       stop_cnt_o,
    output logic       repeat_start_cnt_o,
    output logic [7:0] counter_detect_edge_o,
    output logic [7:0] counter_state_done_time_repeat_start_o,
    output logic       scl_o,
    output logic       ack_bit_o,
    output logic       data_req_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       nack_err_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WADDR, S_RACK, S_WDATA, S_RDATA, S_WACK, S_STOP, S_RSTART
    } state_t;

    localparam logic [7:0] LP_REP = 8'(REP_TIME);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, r_rs_cnt, r_bytes, r_p;
    logic [7:0] w_bytes_nxt, w_p_clamp;
    logic       r_rw, r_sda, r_data_phase, r_nack, r_ack_bit;
    logic       w_wrap, w_byte_done, w_entry;
    logic       w_accept, w_latch, w_set_nack, w_data_req, w_rx_valid;

    always_comb begin
        if (prescaler_i < 8'd2)        w_p_clamp = 8'd2;
        else if (prescaler_i > 8'd127) w_p_clamp = 8'd127;
        else                           w_p_clamp = prescaler_i;
    end

    // Falling SCL edge: last cycle of the 2P+2 period.
    assign w_wrap      = (r_cnt == {r_p[6:0], 1'b1});
    assign w_byte_done = w_wrap && (counter_data_ack_i == 8'd8);
    assign w_entry     = (w_state_nxt != r_state);

    always_comb begin
        w_state_nxt = r_state;
        w_bytes_nxt = r_bytes;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        w_set_nack  = 1'b0;
        w_data_req  = 1'b0;
        w_rx_valid  = 1'b0;
        case (r_state)
            S_IDLE: if (enable_i) begin
                w_accept    = 1'b1;
                w_state_nxt = S_START;
            end
            S_START: if (w_wrap) w_state_nxt = S_WADDR;
            S_WADDR, S_WDATA: if (w_byte_done) w_state_nxt = S_RACK;
            S_RACK: if (w_wrap) begin
                if (r_data_phase && r_bytes != 8'd0) w_bytes_nxt = r_bytes - 8'd1;
                if (r_sda) begin
                    w_set_nack  = 1'b1;
                    w_state_nxt = S_STOP;
                end else if (w_bytes_nxt != 8'd0) begin
                    if (r_rw) begin
                        w_state_nxt = S_RDATA;
                    end else begin
                        w_data_req  = 1'b1;
                        w_state_nxt = S_WDATA;
                    end
                end else begin
                    w_state_nxt = repeat_start_i ? S_RSTART : S_STOP;
                end
            end
            S_RDATA: if (w_byte_done) begin
                w_rx_valid  = 1'b1;
                w_state_nxt = S_WACK;
            end
            S_WACK: if (w_wrap) begin
                if (r_bytes != 8'd0) w_bytes_nxt = r_bytes - 8'd1;
                if (w_bytes_nxt == 8'd0) w_state_nxt = repeat_start_i ? S_RSTART : S_STOP;
                else                     w_state_nxt = S_RDATA;
            end
            S_STOP: if (w_wrap) w_state_nxt = S_IDLE;
            // Leave as the timer steps to 0 so the value 0 lands on WRITE_ADDR entry.
            S_RSTART: if (r_rs_cnt <= 8'd1) begin
                w_latch     = 1'b1;
                w_state_nxt = S_WADDR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_rs_cnt     <= 8'd0;
            r_bytes      <= 8'd0;
            r_p          <= 8'd2;
            r_rw         <= 1'b0;
            r_sda        <= 1'b0;
            r_data_phase <= 1'b0;
            r_nack       <= 1'b0;
            r_ack_bit    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_entry || r_state == S_IDLE || r_state == S_RSTART || w_wrap) r_cnt <= 8'd0;
            else                                                               r_cnt <= r_cnt + 8'd1;
            if (w_entry && w_state_nxt == S_RSTART) r_rs_cnt <= LP_REP;
            else if (r_rs_cnt != 8'd0)              r_rs_cnt <= r_rs_cnt - 8'd1;
            if (w_accept || w_latch) begin
                r_rw    <= addr_rw_i[0];
                r_bytes <= num_bytes_i;
            end else begin
                r_bytes <= w_bytes_nxt;
            end
            if (w_accept) r_p <= w_p_clamp;
            if (r_state == S_RACK && r_cnt == r_p) r_sda <= sda_i;
            if (w_entry && w_state_nxt == S_RACK) r_data_phase <= (r_state == S_WDATA);
            if (w_entry && w_state_nxt == S_RDATA) r_ack_bit <= (w_bytes_nxt == 8'd1);
            if (w_accept)        r_nack <= 1'b0;
            else if (w_set_nack) r_nack <= 1'b1;
        end
    end

    always_comb begin
        case (r_state)
            S_IDLE, S_START: scl_o = 1'b1;
            S_RSTART:        scl_o = (r_rs_cnt <= 8'd2);
            default:         scl_o = (r_cnt >= r_p);
        endcase
    end

    assign start_cnt_o        = (r_state == S_START);
    assign write_addr_cnt_o   = (r_state == S_WADDR);
    assign write_data_cnt_o   = (r_state == S_WDATA);
    assign read_data_cnt_o    = (r_state == S_RDATA);
    assign write_ack_cnt_o    = (r_state == S_WACK);
    assign read_ack_cnt_o     = (r_state == S_RACK);
    assign stop_cnt_o         = (r_state == S_STOP);
    assign repeat_start_cnt_o = (r_state == S_RSTART);

    assign counter_detect_edge_o                  = r_cnt;
    assign counter_state_done_time_repeat_start_o = r_rs_cnt;
    assign ack_bit_o  = r_ack_bit;
    assign data_req_o = w_data_req;
    assign rx_valid_o = w_rx_valid;
    assign busy_o     = (r_state != S_IDLE);
    assign nack_err_o = r_nack;

endmodule
